// File: rtl/md_pkg.sv
// Shared multiply/divide opcodes, HI/LO payload type and the long-op classifier.
// MD_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate opcodes to the long-op set.
package md_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [OP_W-1:0] MD_MADD  = 4'd7;
    localparam logic [OP_W-1:0] MD_MADDU = 4'd8;
    localparam logic [OP_W-1:0] MD_MSUB  = 4'd9;
    localparam logic [OP_W-1:0] MD_MSUBU = 4'd10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Ops that occupy the unit for several cycles and raise busy.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
    import md_pkg::*;

    logic [31:0]     a;
    logic [31:0]     b;
    logic [OP_W-1:0] op;
    logic            start;
    logic            busy;
    logic [31:0]     hi;
    logic [31:0]     lo;

    modport master (output a, b, op, start, input busy, hi, lo);
    modport slave  (input a, b, op, start, output busy, hi, lo);

endinterface

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide, including the DIV overflow and
// divide-by-zero rules. MD_MADD_EN adds the 64-bit accumulate path on {hi,lo}.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [OP_W-1:0] op,
`ifdef MD_MADD_EN
    input  hilo_t           acc,
`endif
    output hilo_t           res_c,
    output logic            wr_c
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] b_nz;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        div_ovf;

    // Low 64 bits of a sign-extended product equal the signed 64-bit product.
    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};

    // Divisor forced nonzero so the unused quotient never goes X; b==0 suppresses the write.
    assign b_nz    = (b == 32'd0) ? 32'd1 : b;
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sq      = 32'($signed(a) / $signed(b_nz));
    assign sr      = 32'($signed(a) % $signed(b_nz));
    assign uq      = a / b_nz;
    assign ur      = a % b_nz;

    always_comb begin
        res_c = '0;
        wr_c  = 1'b0;
        case (op)
            MD_MULT: begin
                res_c = hilo_t'(sprod);
                wr_c  = 1'b1;
            end
            MD_MULTU: begin
                res_c = hilo_t'(uprod);
                wr_c  = 1'b1;
            end
            MD_DIV: begin
                res_c.lo = div_ovf ? a : sq;
                res_c.hi = div_ovf ? 32'd0 : sr;
                wr_c     = (b != 32'd0);
            end
            MD_DIVU: begin
                res_c.lo = uq;
                res_c.hi = ur;
                wr_c     = (b != 32'd0);
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
                res_c = hilo_t'(64'(acc) + sprod);
                wr_c  = 1'b1;
            end
            MD_MADDU: begin
                res_c = hilo_t'(64'(acc) + uprod);
                wr_c  = 1'b1;
            end
            MD_MSUB: begin
                res_c = hilo_t'(64'(acc) - sprod);
                wr_c  = 1'b1;
            end
            MD_MSUBU: begin
                res_c = hilo_t'(64'(acc) - uprod);
                wr_c  = 1'b1;
            end
`endif
            default: begin
                res_c = '0;
                wr_c  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit in EX and sole owner of HI/LO; busy stalls dependents.
// Define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_state_t       state;
    md_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]     opa;
    logic [31:0]     opa_nxt;
    logic [31:0]     opb;
    logic [31:0]     opb_nxt;
    logic [OP_W-1:0] opc;
    logic [OP_W-1:0] opc_nxt;
    hilo_t           hilo;
    hilo_t           hilo_nxt;
    hilo_t           res_c;
    logic            wr_c;

    // Arithmetic runs on operands captured at accept; {hi,lo} is read live at commit.
    md_arith u_arith (
        .a     (opa),
        .b     (opb),
        .op    (opc),
`ifdef MD_MADD_EN
        .acc   (hilo),
`endif
        .res_c (res_c),
        .wr_c  (wr_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            opc   <= MD_NONE;
            hilo  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            opa   <= opa_nxt;
            opb   <= opb_nxt;
            opc   <= opc_nxt;
            hilo  <= hilo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        opa_nxt   = opa;
        opb_nxt   = opb;
        opc_nxt   = opc;
        hilo_nxt  = hilo;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == MD_MTHI) begin
                        hilo_nxt.hi = bus.a;
                    end else if (bus.op == MD_MTLO) begin
                        hilo_nxt.lo = bus.a;
                    end else if (is_long_op(bus.op)) begin
                        opa_nxt   = bus.a;
                        opb_nxt   = bus.b;
                        opc_nxt   = bus.op;
                        cnt_nxt   = is_div_op(bus.op) ? CNT_W'(DIV_CYCLES - 1)
                                                      : CNT_W'(MULT_CYCLES - 1);
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Requests arriving while busy are dropped, not queued.
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    if (wr_c) begin
                        hilo_nxt = res_c;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.hi   = hilo.hi;
    assign bus.lo   = hilo.lo;

endmodule
